// File: rtl/exe_wb_pipe_queue_pkg.sv
// Shared types and widths for the EXE->WB queue.
//   exe_wb_entry_t : one completed micro-op as carried from EXE to WB
//   mask_wb()      : zeroes result data and destination when the entry does not write the RF
package exe_wb_pipe_queue_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PC_W   = 40;
  localparam int unsigned INST_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              csr_en;
    logic              branch;
    logic              xcpt;
    logic [DATA_W-1:0] xcpt_cause;
    logic [PC_W-1:0]   mem_addr;
  } exe_wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(exe_wb_entry_t);

  function automatic exe_wb_entry_t mask_wb(input exe_wb_entry_t e);
    exe_wb_entry_t m;
    m = e;
    if (!e.we) begin
      m.data = '0;
      m.rd   = '0;
    end
    return m;
  endfunction

endpackage

// File: rtl/exe_wb_pipe_queue_fifo.sv
// Generic in-order FIFO, DEPTH x WIDTH, any DEPTH >= 1.
//   clk, rst      : clock, async active-high reset
//   flush         : synchronous clear; wins over push/pop in the same cycle
//   push / wdata  : write one entry (ignored when full)
//   pop  / rdata  : drop the head entry (ignored when empty); rdata is the head
//   count, full, empty : occupancy
module exe_wb_pipe_queue_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths stay in range
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: contents are only observed through count
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/exe_wb_pipe_queue.sv
// EXE->WB pipeline stage as a DEPTH-entry in-order queue with valid/ready on both sides.
//   CLK, RST, FLUSH            : clock, async active-high reset, synchronous kill of all entries
//   EXE_VALID/EXE_READY/EXE_*  : producer side; EXE_READY is a flop (no path from WB_READY)
//   WB_VALID/WB_READY/WB_*     : consumer side; all WB_* read 0 while the queue is empty
//   WB_CSR_DATA                : unmasked head result for CSR writes
//   DRAIN                      : an excepting entry was accepted; intake stays closed until FLUSH
module exe_wb_pipe_queue
  import exe_wb_pipe_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              EXE_VALID,
  output logic              EXE_READY,
  input  logic [PC_W-1:0]   EXE_PC,
  input  logic [INST_W-1:0] EXE_INST,
  input  logic              EXE_WE,
  input  logic [DATA_W-1:0] EXE_DATA,
  input  logic [REG_W-1:0]  EXE_RD,
  input  logic              EXE_CSR_EN,
  input  logic              EXE_BRANCH,
  input  logic              EXE_XCPT,
  input  logic [DATA_W-1:0] EXE_XCPT_CAUSE,
  input  logic [PC_W-1:0]   EXE_MEM_ADDR,
  output logic              WB_VALID,
  input  logic              WB_READY,
  output logic [PC_W-1:0]   WB_PC,
  output logic [INST_W-1:0] WB_INST,
  output logic              WB_WE,
  output logic [DATA_W-1:0] WB_DATA,
  output logic [REG_W-1:0]  WB_RD,
  output logic              WB_CSR_EN,
  output logic              WB_BRANCH,
  output logic              WB_XCPT,
  output logic [DATA_W-1:0] WB_XCPT_CAUSE,
  output logic [PC_W-1:0]   WB_MEM_ADDR,
  output logic [DATA_W-1:0] WB_CSR_DATA,
  output logic              DRAIN
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  exe_wb_entry_t    in_e;
  exe_wb_entry_t    head_e;
  exe_wb_entry_t    out_e;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ready_q;
  logic             ready_nxt;
  logic             drain_q;
  logic             drain_nxt;

  assign in_e = '{pc: EXE_PC, inst: EXE_INST, we: EXE_WE, data: EXE_DATA, rd: EXE_RD,
                  csr_en: EXE_CSR_EN, branch: EXE_BRANCH, xcpt: EXE_XCPT,
                  xcpt_cause: EXE_XCPT_CAUSE, mem_addr: EXE_MEM_ADDR};

  // full is redundant with ready_q; kept as a guard against any overflow
  assign push = EXE_VALID & ready_q & ~full;
  assign pop  = WB_READY & ~empty;

  exe_wb_pipe_queue_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .flush(FLUSH),
    .push (push),
    .pop  (pop),
    .wdata(in_e),
    .rdata(head_e),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // Ready is computed from next-cycle occupancy so a pop into a full queue frees a slot one cycle later
  always_comb begin
    count_nxt = count;
    drain_nxt = drain_q;
    ready_nxt = 1'b0;
    if (FLUSH) begin
      count_nxt = '0;
      drain_nxt = 1'b0;
    end else begin
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      drain_nxt = drain_q | (push & EXE_XCPT);
    end
    ready_nxt = (count_nxt < CNT_W'(DEPTH)) & ~drain_nxt & ~FLUSH;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      ready_q <= ready_nxt;
      drain_q <= drain_nxt;
    end
  end

  // Empty queue presents all-zero outputs rather than stale storage
  assign out_e = empty ? '0 : mask_wb(head_e);

  assign EXE_READY     = ready_q;
  assign DRAIN         = drain_q;
  assign WB_VALID      = ~empty;
  assign WB_PC         = out_e.pc;
  assign WB_INST       = out_e.inst;
  assign WB_WE         = out_e.we;
  assign WB_DATA       = out_e.data;
  assign WB_RD         = out_e.rd;
  assign WB_CSR_EN     = out_e.csr_en;
  assign WB_BRANCH     = out_e.branch;
  assign WB_XCPT       = out_e.xcpt;
  assign WB_XCPT_CAUSE = out_e.xcpt_cause;
  assign WB_MEM_ADDR   = out_e.mem_addr;
  assign WB_CSR_DATA   = empty ? '0 : head_e.data;

endmodule

// File: tb/tb_exe_wb_pipe_queue.sv
// Bench for exe_wb_pipe_queue: a DEPTH=2 and a DEPTH=3 instance share stimulus; one is checked at a time.
module tb_exe_wb_pipe_queue;
  import exe_wb_pipe_queue_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          exe_valid;
  logic          wb_ready;
  exe_wb_entry_t drv;

  logic              r_ready  [2];
  logic              r_valid  [2];
  logic              r_drain  [2];
  logic [PC_W-1:0]   r_pc     [2];
  logic [INST_W-1:0] r_inst   [2];
  logic              r_we     [2];
  logic [DATA_W-1:0] r_data   [2];
  logic [REG_W-1:0]  r_rd     [2];
  logic              r_csr_en [2];
  logic              r_branch [2];
  logic              r_xcpt   [2];
  logic [DATA_W-1:0] r_cause  [2];
  logic [PC_W-1:0]   r_maddr  [2];
  logic [DATA_W-1:0] r_csrd   [2];

  exe_wb_pipe_queue #(.DEPTH(2)) u_d2 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .EXE_VALID(exe_valid), .EXE_READY(r_ready[0]),
    .EXE_PC(drv.pc), .EXE_INST(drv.inst), .EXE_WE(drv.we), .EXE_DATA(drv.data), .EXE_RD(drv.rd),
    .EXE_CSR_EN(drv.csr_en), .EXE_BRANCH(drv.branch), .EXE_XCPT(drv.xcpt),
    .EXE_XCPT_CAUSE(drv.xcpt_cause), .EXE_MEM_ADDR(drv.mem_addr),
    .WB_VALID(r_valid[0]), .WB_READY(wb_ready), .WB_PC(r_pc[0]), .WB_INST(r_inst[0]),
    .WB_WE(r_we[0]), .WB_DATA(r_data[0]), .WB_RD(r_rd[0]), .WB_CSR_EN(r_csr_en[0]),
    .WB_BRANCH(r_branch[0]), .WB_XCPT(r_xcpt[0]), .WB_XCPT_CAUSE(r_cause[0]),
    .WB_MEM_ADDR(r_maddr[0]), .WB_CSR_DATA(r_csrd[0]), .DRAIN(r_drain[0])
  );

  exe_wb_pipe_queue #(.DEPTH(3)) u_d3 (
    .CLK(clk), .RST(rst), .FLUSH(flush), .EXE_VALID(exe_valid), .EXE_READY(r_ready[1]),
    .EXE_PC(drv.pc), .EXE_INST(drv.inst), .EXE_WE(drv.we), .EXE_DATA(drv.data), .EXE_RD(drv.rd),
    .EXE_CSR_EN(drv.csr_en), .EXE_BRANCH(drv.branch), .EXE_XCPT(drv.xcpt),
    .EXE_XCPT_CAUSE(drv.xcpt_cause), .EXE_MEM_ADDR(drv.mem_addr),
    .WB_VALID(r_valid[1]), .WB_READY(wb_ready), .WB_PC(r_pc[1]), .WB_INST(r_inst[1]),
    .WB_WE(r_we[1]), .WB_DATA(r_data[1]), .WB_RD(r_rd[1]), .WB_CSR_EN(r_csr_en[1]),
    .WB_BRANCH(r_branch[1]), .WB_XCPT(r_xcpt[1]), .WB_XCPT_CAUSE(r_cause[1]),
    .WB_MEM_ADDR(r_maddr[1]), .WB_CSR_DATA(r_csrd[1]), .DRAIN(r_drain[1])
  );

  int            n_vec = 0;
  int            n_bad = 0;
  int            sel = 0;
  int            depth_m = 2;
  exe_wb_entry_t sb[$];
  logic          m_ready;
  logic          m_drain;

  typedef struct {
    logic              vld;
    logic              rdy;
    logic              fl;
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              xcpt;
    logic [DATA_W-1:0] cause;
    logic              e_ready;
    logic              e_valid;
    logic              e_drain;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (depth %0d) t=%0t: got 0x%0h expected 0x%0h", name, depth_m, $time, act, exp);
    end
  endtask

  function automatic exe_wb_entry_t mk(input logic [PC_W-1:0] pc, input logic we,
                                       input logic [DATA_W-1:0] data, input logic [REG_W-1:0] rd,
                                       input logic xcpt, input logic [DATA_W-1:0] cause);
    exe_wb_entry_t e;
    e.pc         = pc;
    e.inst       = 32'h0000_0013 ^ pc[31:0];
    e.we         = we;
    e.data       = data;
    e.rd         = rd;
    e.csr_en     = pc[2];
    e.branch     = pc[3];
    e.xcpt       = xcpt;
    e.xcpt_cause = cause;
    e.mem_addr   = pc + 40'h1000;
    return e;
  endfunction

  function automatic vec_t vec(input logic vld, input logic rdy, input logic fl,
                               input logic [PC_W-1:0] pc, input logic we, input logic [DATA_W-1:0] data,
                               input logic [REG_W-1:0] rd, input logic xcpt, input logic [DATA_W-1:0] cause,
                               input logic er, input logic ev, input logic ed);
    vec_t v;
    v = '{vld, rdy, fl, pc, we, data, rd, xcpt, cause, er, ev, ed};
    return v;
  endfunction

  // Compare every output of the selected instance against the model and scoreboard head
  task automatic check_outputs();
    exe_wb_entry_t h;
    logic          v;
    v = (sb.size() != 0);
    h = v ? sb[0] : '0;
    chk("exe_ready",  64'(r_ready[sel]),  64'(m_ready));
    chk("wb_valid",   64'(r_valid[sel]),  64'(v));
    chk("drain",      64'(r_drain[sel]),  64'(m_drain));
    chk("wb_pc",      64'(r_pc[sel]),     64'(h.pc));
    chk("wb_inst",    64'(r_inst[sel]),   64'(h.inst));
    chk("wb_we",      64'(r_we[sel]),     64'(h.we));
    chk("wb_data",    r_data[sel],        h.we ? h.data : 64'h0);
    chk("wb_rd",      64'(r_rd[sel]),     h.we ? 64'(h.rd) : 64'h0);
    chk("wb_csr_en",  64'(r_csr_en[sel]), 64'(h.csr_en));
    chk("wb_branch",  64'(r_branch[sel]), 64'(h.branch));
    chk("wb_xcpt",    64'(r_xcpt[sel]),   64'(h.xcpt));
    chk("wb_cause",   r_cause[sel],       h.xcpt_cause);
    chk("wb_maddr",   64'(r_maddr[sel]),  64'(h.mem_addr));
    chk("wb_csr_data", r_csrd[sel],       h.data);
  endtask

  // One clock: drive at posedge+1, check, then advance the model across the edge
  task automatic step(input logic vld, input logic rdy, input logic fl, input exe_wb_entry_t e);
    logic push;
    logic pop;
    exe_valid = vld;
    wb_ready  = rdy;
    flush     = fl;
    drv       = e;
    #1;
    check_outputs();
    push = vld & m_ready;
    pop  = rdy & (sb.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      m_drain = 1'b0;
      m_ready = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) begin
        sb.push_back(e);
        if (e.xcpt) m_drain = 1'b1;
      end
      m_ready = (sb.size() < depth_m) && !m_drain;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    exe_valid = 1'b0;
    wb_ready  = 1'b0;
    flush     = 1'b0;
    drv       = '0;
    sb.delete();
    m_ready   = 1'b0;
    m_drain   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    exe_wb_entry_t e;
    logic          vld;
    logic          rdy;
    logic          fl;

    // Fill / masking / drain / flush-collision on DEPTH=2; ready/valid/drain columns are pre-edge state
    tbl[0]  = vec(1, 0, 0, 40'h100, 1, 64'h11,   5'd3, 0, 64'h0, 1, 0, 0);
    tbl[1]  = vec(1, 0, 0, 40'h104, 0, 64'hDEAD, 5'd7, 0, 64'h0, 1, 1, 0);
    tbl[2]  = vec(1, 0, 0, 40'h108, 1, 64'h22,   5'd4, 0, 64'h0, 0, 1, 0);
    tbl[3]  = vec(1, 1, 0, 40'h108, 1, 64'h22,   5'd4, 0, 64'h0, 0, 1, 0);
    tbl[4]  = vec(0, 1, 0, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 1, 1, 0);
    tbl[5]  = vec(1, 0, 0, 40'h200, 1, 64'h55,   5'd9, 1, 64'h2, 1, 0, 0);
    tbl[6]  = vec(1, 1, 0, 40'h204, 1, 64'h66,   5'd1, 0, 64'h0, 0, 1, 1);
    tbl[7]  = vec(0, 1, 0, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 0, 0, 1);
    tbl[8]  = vec(0, 0, 1, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 0, 0, 1);
    tbl[9]  = vec(0, 0, 0, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 0, 0, 0);
    tbl[10] = vec(0, 0, 0, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 1, 0, 0);
    tbl[11] = vec(1, 0, 0, 40'h300, 1, 64'h77,   5'd2, 0, 64'h0, 1, 0, 0);
    tbl[12] = vec(1, 1, 1, 40'h304, 1, 64'h88,   5'd6, 0, 64'h0, 1, 1, 0);
    tbl[13] = vec(0, 1, 0, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 0, 0, 0);
    tbl[14] = vec(0, 0, 0, 40'h0,   0, 64'h0,    5'd0, 0, 64'h0, 1, 0, 0);

    sel = 0;
    depth_m = 2;
    do_reset();
    step(0, 0, 0, '0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tbl%0d_ready", i), 64'(r_ready[sel]), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 64'(r_valid[sel]), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_drain", i), 64'(r_drain[sel]), 64'(tbl[i].e_drain));
      step(tbl[i].vld, tbl[i].rdy, tbl[i].fl,
           mk(tbl[i].pc, tbl[i].we, tbl[i].data, tbl[i].rd, tbl[i].xcpt, tbl[i].cause));
    end

    // Asynchronous reset with two entries queued
    step(1, 0, 0, mk(40'h500, 1, 64'hA1, 5'd1, 0, 64'h0));
    step(1, 0, 0, mk(40'h504, 1, 64'hA2, 5'd2, 0, 64'h0));
    chk("pre_reset_valid", 64'(r_valid[sel]), 64'h1);
    rst = 1'b1;
    #1;
    sb.delete();
    m_ready = 1'b0;
    m_drain = 1'b0;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, '0);
    m_ready = 1'b1;
    chk("ready_after_reset", 64'(r_ready[sel]), 64'h1);
    step(0, 0, 0, '0);

    // Full-rate streaming through DEPTH=3 exercises the non-power-of-two wrap
    sel = 1;
    depth_m = 3;
    do_reset();
    for (int i = 0; i < 12; i++)
      step(1, 1, 0, mk(40'h400 + 40'(4 * i), i[0], 64'h1000 + 64'(i), 5'(i), 0, 64'h0));
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);

    // Random traffic on DEPTH=3 with occasional back-pressure, exceptions and flushes
    for (int i = 0; i < 80; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      e = mk(40'(32'($urandom) & 32'hFFFF_FFFC), 1'($urandom), {$urandom, $urandom},
             5'($urandom), ($urandom_range(0, 11) == 0), 64'($urandom_range(0, 15)));
      step(vld, rdy, fl, e);
      if (m_drain && $urandom_range(0, 3) == 0) step(0, 1, 1, '0);
    end
    step(0, 1, 1, '0);
    step(0, 1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
